// File: rtl/pwm_pkg.sv
// Shared types and helpers for the PWM brightness controller.
package pwm_pkg;

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} btn_state_t;
  typedef enum logic {OWN_UP, OWN_DN} owner_t;

  localparam int DUTY_W_DEF = 4;

  // Saturating +/-1 step; never wraps at either end.
  function automatic int sat_step(input int val, input int max_v, input logic up);
    if (up) return (val >= max_v) ? max_v : val + 1;
    return (val <= 0) ? 0 : val - 1;
  endfunction

endpackage

// File: rtl/btn_conditioner.sv
// Raw button -> 2-flop synchroniser -> debounced level plus one-cycle press pulse on the debounced rise.
module btn_conditioner #(
  parameter int DEBOUNCE_CYC = 16
) (
  input  logic pwm_clk,
  input  logic reset_n,
  input  logic i_raw,
  output logic o_level,
  output logic o_press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);

  logic [1:0]       r_sync;
  logic [CNT_W-1:0] r_cnt;
  logic             r_level;
  logic             r_level_d;

  // The level flips only after DEBOUNCE_CYC consecutive samples disagree with it.
  always_ff @(posedge pwm_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync    <= '0;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
    end else begin
      r_sync    <= {r_sync[0], i_raw};
      r_level_d <= r_level;
      if (r_sync[1] == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_W'(DEBOUNCE_CYC - 1)) begin
        r_level <= r_sync[1];
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_level = r_level;
  assign o_press = r_level & ~r_level_d;

endmodule

// File: rtl/pwm_brightness_ctrl.sv
// LED brightness sequencer: button FSM with hold/auto-repeat, shadowed duty, PWM period counter.
// Optional breathe mode is compiled in with `define PWM_BREATHE_EN.
module pwm_brightness_ctrl
  import pwm_pkg::*;
#(
  parameter int DUTY_W       = DUTY_W_DEF,
  parameter int DUTY_RESET   = 8,
  parameter int DEBOUNCE_CYC = 16,
  parameter int HOLD_CYC     = 64,
  parameter int REPEAT_CYC   = 16,
  parameter int BREATHE_CYC  = 32
) (
  input  logic              pwm_clk,
  input  logic              reset_n,
  input  logic              btn_up_raw,
  input  logic              btn_dn_raw,
  input  logic              btn_mode,
  output logic              pwm_out,
  output logic [DUTY_W-1:0] duty,
  output logic              period_start,
  output logic              breathing,
  output btn_state_t        dbg_state
);

  localparam logic [DUTY_W-1:0] DUTY_MAX = '1;
  localparam logic [DUTY_W-1:0] PCNT_MAX = DUTY_W'((1 << DUTY_W) - 2);
  localparam logic [DUTY_W-1:0] DUTY_RST = DUTY_W'(DUTY_RESET);
  localparam int                TMR_W    = $clog2(HOLD_CYC + 1);

  generate
    if (DUTY_W < 2 || DEBOUNCE_CYC < 2 || REPEAT_CYC < 2 || HOLD_CYC <= REPEAT_CYC) begin : g_bad_params
      $error("pwm_brightness_ctrl: need DUTY_W>=2, DEBOUNCE_CYC>=2, HOLD_CYC>REPEAT_CYC>=2");
    end
  endgenerate

  logic w_up_lvl, w_up_press, w_dn_lvl, w_dn_press, w_owner_lvl, w_breathing;
  logic w_step, w_step_up;
  btn_state_t r_state, w_state_nxt;
  owner_t     r_owner, w_owner_nxt;
  logic [TMR_W-1:0]  r_tmr, w_tmr_nxt;
  logic [DUTY_W-1:0] r_duty_req, w_duty_req_nxt, r_duty, r_pcnt;
  logic              r_pwm, r_period_start;

  btn_conditioner #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_up (
    .pwm_clk(pwm_clk), .reset_n(reset_n), .i_raw(btn_up_raw), .o_level(w_up_lvl), .o_press(w_up_press)
  );
  btn_conditioner #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_dn (
    .pwm_clk(pwm_clk), .reset_n(reset_n), .i_raw(btn_dn_raw), .o_level(w_dn_lvl), .o_press(w_dn_press)
  );

`ifdef PWM_BREATHE_EN
  localparam int BCNT_W = $clog2(BREATHE_CYC + 1);
  logic              w_mode_press, w_unused_mode_lvl, r_breathing, r_ramp_up, w_ramp_up_nxt;
  logic [DUTY_W-1:0] r_saved, w_ramp_val;
  logic [BCNT_W-1:0] r_bcnt;

  btn_conditioner #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_mode (
    .pwm_clk(pwm_clk), .reset_n(reset_n), .i_raw(btn_mode), .o_level(w_unused_mode_lvl), .o_press(w_mode_press)
  );

  // Triangle ramp 0..max..0: turn around at either end instead of saturating.
  always_comb begin
    w_ramp_val    = r_duty_req;
    w_ramp_up_nxt = r_ramp_up;
    if (r_ramp_up) begin
      if (r_duty_req == DUTY_MAX) begin
        w_ramp_val    = DUTY_MAX - 1'b1;
        w_ramp_up_nxt = 1'b0;
      end else begin
        w_ramp_val = r_duty_req + 1'b1;
      end
    end else if (r_duty_req == '0) begin
      w_ramp_val    = DUTY_W'(1);
      w_ramp_up_nxt = 1'b1;
    end else begin
      w_ramp_val = r_duty_req - 1'b1;
    end
  end

  always_ff @(posedge pwm_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_breathing <= 1'b0;
      r_ramp_up   <= 1'b1;
      r_saved     <= DUTY_RST;
      r_bcnt      <= '0;
    end else if (w_mode_press) begin
      r_breathing <= ~r_breathing;
      r_ramp_up   <= 1'b1;
      r_bcnt      <= '0;
      if (!r_breathing) r_saved <= r_duty_req;
    end else if (r_breathing) begin
      if (r_bcnt == BCNT_W'(BREATHE_CYC - 1)) begin
        r_bcnt    <= '0;
        r_ramp_up <= w_ramp_up_nxt;
      end else begin
        r_bcnt <= r_bcnt + 1'b1;
      end
    end
  end

  assign w_breathing = r_breathing;
`else
  logic w_unused_mode;
  assign w_unused_mode = btn_mode;
  assign w_breathing   = 1'b0;
`endif

  assign breathing = w_breathing;

  // Release of the owner button takes priority over a step due on the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_tmr_nxt   = r_tmr;
    w_step      = 1'b0;
    w_step_up   = (r_owner == OWN_UP);
    w_owner_lvl = (r_owner == OWN_UP) ? w_up_lvl : w_dn_lvl;
    case (r_state)
      IDLE: begin
        if (w_up_press ^ w_dn_press) begin
          w_step      = 1'b1;
          w_step_up   = w_up_press;
          w_owner_nxt = w_up_press ? OWN_UP : OWN_DN;
          w_state_nxt = HOLD;
          w_tmr_nxt   = '0;
        end
      end
      HOLD: begin
        if (!w_owner_lvl) begin
          w_state_nxt = IDLE;
        end else if (r_tmr == TMR_W'(HOLD_CYC - 1)) begin
          w_step      = 1'b1;
          w_state_nxt = REPEAT;
          w_tmr_nxt   = '0;
        end else begin
          w_tmr_nxt = r_tmr + 1'b1;
        end
      end
      REPEAT: begin
        if (!w_owner_lvl) begin
          w_state_nxt = IDLE;
        end else if (r_tmr == TMR_W'(REPEAT_CYC - 1)) begin
          w_step    = 1'b1;
          w_tmr_nxt = '0;
        end else begin
          w_tmr_nxt = r_tmr + 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (w_breathing) begin
      w_state_nxt = IDLE;
      w_step      = 1'b0;
      w_tmr_nxt   = '0;
    end
  end

  always_comb begin
    w_duty_req_nxt = r_duty_req;
    if (w_step) w_duty_req_nxt = DUTY_W'(sat_step(int'(r_duty_req), int'(DUTY_MAX), w_step_up));
`ifdef PWM_BREATHE_EN
    if (w_mode_press) w_duty_req_nxt = r_breathing ? r_saved : '0;
    else if (r_breathing && r_bcnt == BCNT_W'(BREATHE_CYC - 1)) w_duty_req_nxt = w_ramp_val;
`endif
  end

  always_ff @(posedge pwm_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= IDLE;
      r_owner        <= OWN_UP;
      r_tmr          <= '0;
      r_duty_req     <= DUTY_RST;
      r_duty         <= DUTY_RST;
      r_pcnt         <= '0;
      r_pwm          <= 1'b0;
      r_period_start <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_owner        <= w_owner_nxt;
      r_tmr          <= w_tmr_nxt;
      r_duty_req     <= w_duty_req_nxt;
      r_pwm          <= (r_pcnt < r_duty);
      r_period_start <= (r_pcnt == PCNT_MAX);
      // The active duty only picks up the request as the counter wraps.
      if (r_pcnt == PCNT_MAX) begin
        r_pcnt <= '0;
        r_duty <= r_duty_req;
      end else begin
        r_pcnt <= r_pcnt + 1'b1;
      end
    end
  end

  assign pwm_out      = r_pwm;
  assign duty         = r_duty;
  assign period_start = r_period_start;
  assign dbg_state    = r_state;

endmodule
